// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and the pipeline sequencer state encoding
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        RUN,
        SERVED,
        HALTED
    } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: sequencer <-> datapath bundle; PIPE_PERF_CNT_EN adds the perf counter lines
interface pipeline_ctrl_if
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = $bits(word_t),
    parameter int REG_W  = $bits(regbits_t)
);

    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;
    logic              exmem_dREN;
    logic              exmem_dWEN;
    logic              exmem_redirect;
    logic              idex_MemtoReg;
    logic [REG_W-1:0]  idex_wsel;
    logic [REG_W-1:0]  ifid_rs;
    logic [REG_W-1:0]  ifid_rt;
    logic              memwb_halt;
    logic              pc_wen;
    logic              ifid_wen;
    logic              idex_wen;
    logic              exmem_wen;
    logic              memwb_wen;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic              dREN_out;
    logic              dWEN_out;
    logic [WORD_W-1:0] dmemload_out;
    logic              halt;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        input  ihit, dhit, dmemload, exmem_dREN, exmem_dWEN, exmem_redirect,
               idex_MemtoReg, idex_wsel, ifid_rs, ifid_rt, memwb_halt,
`ifdef PIPE_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, exmem_flush,
               dREN_out, dWEN_out, dmemload_out, halt
    );

    modport slave (
        output ihit, dhit, dmemload, exmem_dREN, exmem_dWEN, exmem_redirect,
               idex_MemtoReg, idex_wsel, ifid_rs, ifid_rt, memwb_halt,
`ifdef PIPE_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
               ifid_flush, idex_flush, exmem_flush,
               dREN_out, dWEN_out, dmemload_out, halt
    );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use check between ID/EX load and IF/ID sources
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             idex_MemtoReg,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    output logic             lu
);

    // register 0 is hardwired, so a load targeting it never creates a dependency
    assign lu = idex_MemtoReg & (idex_wsel != '0) &
                ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipe; define PIPE_PERF_CNT_EN for stall/flush counters
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = $bits(word_t),
    parameter int REG_W  = $bits(regbits_t)
) (
    input  logic            clk,
    input  logic            nRst,
    pipeline_ctrl_if.master pif
);

    pctrl_state_t      st;
    logic [WORD_W-1:0] hold_data;
    logic              mem_req, dstall, adv, lu, pc_go;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_MemtoReg(pif.idex_MemtoReg),
        .idex_wsel    (pif.idex_wsel),
        .ifid_rs      (pif.ifid_rs),
        .ifid_rt      (pif.ifid_rt),
        .lu           (lu)
    );

    // an access already served while frozen must not stall the pipe again
    assign mem_req = pif.exmem_dREN | pif.exmem_dWEN;
    assign dstall  = mem_req & ~pif.dhit & (st != SERVED);
    assign adv     = nRst & pif.ihit & ~dstall & (st != HALTED);
    // a redirect replaces the stalled fetch, so it overrides the load-use hold
    assign pc_go   = adv & (~lu | pif.exmem_redirect);

    assign pif.pc_wen       = pc_go;
    assign pif.ifid_wen     = pc_go;
    assign pif.idex_wen     = adv;
    assign pif.exmem_wen    = adv;
    assign pif.memwb_wen    = adv;
    assign pif.ifid_flush   = adv & pif.exmem_redirect;
    assign pif.idex_flush   = adv & (lu | pif.exmem_redirect);
    assign pif.exmem_flush  = adv & pif.exmem_redirect;
    assign pif.dREN_out     = nRst & pif.exmem_dREN & (st == RUN);
    assign pif.dWEN_out     = nRst & pif.exmem_dWEN & (st == RUN);
    assign pif.dmemload_out = !nRst ? '0 : (st == SERVED) ? hold_data : pif.dmemload;
    assign pif.halt         = (st == HALTED);

    // sequencer: halt wins, else latch a served dcache access while icache misses
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            st        <= RUN;
            hold_data <= '0;
        end else if (pif.memwb_halt & adv) begin
            st <= HALTED;
        end else if (st == RUN && mem_req && pif.dhit && !adv) begin
            st        <= SERVED;
            hold_data <= pif.dmemload;
        end else if (st == SERVED && adv) begin
            st <= RUN;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    assign pif.stall_cnt = stall_cnt;
    assign pif.flush_cnt = flush_cnt;

    // stall and flush cycle counters, frozen once the core halts
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (st != HALTED) begin
            stall_cnt <= stall_cnt + {31'd0, ~adv};
            flush_cnt <= flush_cnt + {31'd0, pif.ifid_flush | pif.idex_flush};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed + random checks of pipeline_ctrl against a cycle-level reference model
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if pif ();
    pipeline_ctrl dut (.clk(clk), .nRst(nRst), .pif(pif));

    int errs = 0;
    int checks = 0;

    bit          m_served, m_halted;
    logic [31:0] m_hold;
    int unsigned m_stall, m_flush;

    // {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, exmem_flush, dREN_out, dWEN_out, halt}
    wire [10:0] obs = {pif.pc_wen, pif.ifid_wen, pif.idex_wen, pif.exmem_wen, pif.memwb_wen,
                       pif.ifid_flush, pif.idex_flush, pif.exmem_flush,
                       pif.dREN_out, pif.dWEN_out, pif.halt};

    function automatic logic m_haz();
        return pif.idex_MemtoReg && pif.idex_wsel != 0 &&
               (pif.idex_wsel == pif.ifid_rs || pif.idex_wsel == pif.ifid_rt);
    endfunction

    function automatic logic m_adv();
        logic waiting_dcache;
        waiting_dcache = (pif.exmem_dREN || pif.exmem_dWEN) && !pif.dhit && !m_served;
        return nRst && pif.ihit && !waiting_dcache && !m_halted;
    endfunction

    function automatic logic [10:0] exp_ctl();
        logic go, hz, r, idle_mem;
        go = m_adv();
        hz = m_haz();
        r  = pif.exmem_redirect;
        idle_mem = nRst && !m_served && !m_halted;
        return {go && (!hz || r), go && (!hz || r), go, go, go,
                go && r, go && (hz || r), go && r,
                idle_mem && pif.exmem_dREN, idle_mem && pif.exmem_dWEN, m_halted};
    endfunction

    function automatic logic [31:0] exp_data();
        return !nRst ? 32'd0 : m_served ? m_hold : pif.dmemload;
    endfunction

    task automatic drive_idle();
        pif.ihit = 1; pif.dhit = 0; pif.dmemload = $urandom;
        pif.exmem_dREN = 0; pif.exmem_dWEN = 0; pif.exmem_redirect = 0;
        pif.idex_MemtoReg = 0; pif.idex_wsel = 0; pif.ifid_rs = 0; pif.ifid_rt = 0;
        pif.memwb_halt = 0;
    endtask

    task automatic model_reset();
        m_served = 0; m_halted = 0; m_hold = 0; m_stall = 0; m_flush = 0;
    endtask

    // advance one clock and apply the spec's rules to the model
    task automatic tick();
        logic go, mreq, fl;
        go   = m_adv();
        mreq = pif.exmem_dREN || pif.exmem_dWEN;
        fl   = go && (m_haz() || pif.exmem_redirect);
        @(posedge clk);
        if (nRst) begin
            if (!m_halted) begin
                if (!go) m_stall++;
                if (fl) m_flush++;
            end
            if (pif.memwb_halt && go) m_halted = 1;
            else if (!m_served && !m_halted && mreq && pif.dhit && !go) begin
                m_served = 1;
                m_hold   = pif.dmemload;
            end else if (m_served && go) m_served = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        pif.exmem_dREN = 1; pif.exmem_redirect = 1;
        model_reset();
        #1;
        checks++;
        if (obs !== 11'd0) begin errs++; $display("FAIL reset_ctl got=%b exp=%b", obs, 11'd0); end
        checks++;
        if (pif.dmemload_out !== 32'd0) begin errs++; $display("FAIL reset_data got=%h exp=0", pif.dmemload_out); end
        @(posedge clk); #1;
        nRst = 1;
        drive_idle();
        #2;
        checks++;
        if (obs !== 11'b11111000000) begin errs++; $display("FAIL reset_release got=%b exp=%b", obs, 11'b11111000000); end
        tick();
    endtask

    task automatic test_load_use();
        drive_idle();
        pif.idex_MemtoReg = 1; pif.idex_wsel = 5; pif.ifid_rs = 5; pif.ifid_rt = 9;
        #2;
        checks++;
        if (obs !== 11'b00111010000) begin errs++; $display("FAIL load_use got=%b exp=%b", obs, 11'b00111010000); end
        tick();
        drive_idle();
        #2;
        checks++;
        if (obs !== 11'b11111000000) begin errs++; $display("FAIL load_use_release got=%b exp=%b", obs, 11'b11111000000); end
        tick();
        pif.idex_MemtoReg = 1; pif.idex_wsel = 0; pif.ifid_rs = 0; pif.ifid_rt = 0;
        #2;
        checks++;
        if (obs !== 11'b11111000000) begin errs++; $display("FAIL load_r0 got=%b exp=%b", obs, 11'b11111000000); end
        tick();
        pif.idex_wsel = 7; pif.ifid_rs = 3; pif.ifid_rt = 7; pif.exmem_redirect = 1;
        #2;
        checks++;
        if (obs !== 11'b11111111000) begin errs++; $display("FAIL lu_redirect got=%b exp=%b", obs, 11'b11111111000); end
        tick();
    endtask

    task automatic test_dmiss();
        drive_idle();
        pif.exmem_dREN = 1; pif.dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs !== 11'b00000000100) begin errs++; $display("FAIL dmiss_%0d got=%b exp=%b", i, obs, 11'b00000000100); end
            tick();
        end
        pif.dhit = 1;
        #2;
        checks++;
        if (obs !== 11'b11111000100) begin errs++; $display("FAIL dmiss_hit got=%b exp=%b", obs, 11'b11111000100); end
        tick();
    endtask

    task automatic test_served();
        drive_idle();
        pif.exmem_dREN = 1; pif.dhit = 1; pif.ihit = 0; pif.dmemload = 32'hDEADBEEF;
        #2;
        checks++;
        if (obs !== exp_ctl()) begin errs++; $display("FAIL served_entry got=%b exp=%b", obs, exp_ctl()); end
        tick();
        for (int i = 0; i < 2; i++) begin
            pif.dmemload = $urandom; pif.dhit = 1'($urandom);
            #2;
            checks++;
            if (obs !== 11'b00000000000) begin errs++; $display("FAIL served_hold_ctl got=%b exp=%b", obs, 11'd0); end
            checks++;
            if (pif.dmemload_out !== 32'hDEADBEEF) begin errs++; $display("FAIL served_hold_data got=%h exp=deadbeef", pif.dmemload_out); end
            tick();
        end
        pif.ihit = 1; pif.dhit = 0;
        #2;
        checks++;
        if (obs !== 11'b11111000000 || pif.dmemload_out !== 32'hDEADBEEF) begin
            errs++; $display("FAIL served_release got=%b/%h exp=%b/deadbeef", obs, pif.dmemload_out, 11'b11111000000);
        end
        tick();
        pif.dhit = 1;
        #2;
        checks++;
        if (obs !== 11'b11111000100 || pif.dmemload_out !== pif.dmemload) begin
            errs++; $display("FAIL served_back_to_run got=%b/%h exp=%b/%h", obs, pif.dmemload_out, 11'b11111000100, pif.dmemload);
        end
        tick();
    endtask

    task automatic test_redirect();
        drive_idle();
        pif.exmem_redirect = 1;
        #2;
        checks++;
        if (obs !== 11'b11111111000) begin errs++; $display("FAIL redirect got=%b exp=%b", obs, 11'b11111111000); end
        tick();
        pif.ihit = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (obs !== 11'd0) begin errs++; $display("FAIL redirect_frozen_%0d got=%b exp=%b", i, obs, 11'd0); end
            tick();
        end
        pif.ihit = 1;
        #2;
        checks++;
        if (obs !== 11'b11111111000) begin errs++; $display("FAIL redirect_late got=%b exp=%b", obs, 11'b11111111000); end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            pif.ihit = ($urandom_range(0, 3) != 0);
            pif.dhit = 1'($urandom);
            pif.dmemload = $urandom;
            pif.exmem_dREN = ($urandom_range(0, 2) == 0);
            pif.exmem_dWEN = !pif.exmem_dREN && ($urandom_range(0, 3) == 0);
            pif.exmem_redirect = ($urandom_range(0, 5) == 0);
            pif.idex_MemtoReg = ($urandom_range(0, 2) == 0);
            pif.idex_wsel = 5'($urandom_range(0, 3));
            pif.ifid_rs = 5'($urandom_range(0, 3));
            pif.ifid_rt = 5'($urandom_range(0, 3));
            pif.memwb_halt = 0;
            #2;
            checks++;
            if (obs !== exp_ctl() || pif.dmemload_out !== exp_data()) begin
                errs++; bad++;
                if (bad <= 10) $display("FAIL random_%0d got=%b/%h exp=%b/%h", i, obs, pif.dmemload_out, exp_ctl(), exp_data());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_served();
        drive_idle();
        pif.exmem_dREN = 1; pif.dhit = 1; pif.ihit = 0; pif.dmemload = 32'h12345678;
        tick();
        pif.dmemload = 32'h0;
        #2;
        checks++;
        if (pif.dmemload_out !== 32'h12345678) begin errs++; $display("FAIL mid_served_hold got=%h exp=12345678", pif.dmemload_out); end
        nRst = 0;
        model_reset();
        #1;
        nRst = 1;
        pif.dmemload = 32'hA5A5A5A5; pif.dhit = 0;
        #1;
        checks++;
        if (pif.dmemload_out !== 32'hA5A5A5A5 || obs !== 11'b00000000100) begin
            errs++; $display("FAIL mid_served_discard got=%h/%b exp=a5a5a5a5/%b", pif.dmemload_out, obs, 11'b00000000100);
        end
        tick();
    endtask

    task automatic test_halt();
        drive_idle();
        pif.ihit = 0; pif.dhit = 0; pif.exmem_dREN = 1;
        tick();
        tick();
        drive_idle();
        pif.memwb_halt = 1; pif.exmem_redirect = 1;
        #2;
        checks++;
        if (obs !== exp_ctl()) begin errs++; $display("FAIL halt_trigger got=%b exp=%b", obs, exp_ctl()); end
        tick();
        for (int i = 0; i < 4; i++) begin
            pif.ihit = 1'($urandom); pif.dhit = 1'($urandom);
            pif.exmem_dREN = 1'($urandom); pif.exmem_dWEN = 1'($urandom);
            pif.exmem_redirect = 1'($urandom);
            #2;
            checks++;
            if (obs !== 11'b00000000001) begin errs++; $display("FAIL halted_%0d got=%b exp=%b", i, obs, 11'b00000000001); end
            tick();
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (pif.stall_cnt !== m_stall) begin errs++; $display("FAIL stall_cnt got=%0d exp=%0d", pif.stall_cnt, m_stall); end
        checks++;
        if (pif.flush_cnt !== m_flush) begin errs++; $display("FAIL flush_cnt got=%0d exp=%0d", pif.flush_cnt, m_flush); end
`endif
        #2;
        nRst = 0;
        model_reset();
        #1;
        checks++;
        if (pif.halt !== 1'b0 || obs !== 11'd0) begin errs++; $display("FAIL halt_reset got=%b exp=%b", obs, 11'd0); end
        nRst = 1;
        drive_idle();
        #1;
        checks++;
        if (obs !== 11'b11111000000) begin errs++; $display("FAIL halt_rerun got=%b exp=%b", obs, 11'b11111000000); end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (pif.stall_cnt !== 32'd0 || pif.flush_cnt !== 32'd0) begin
            errs++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", pif.stall_cnt, pif.flush_cnt);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss();
        test_served();
        test_redirect();
        test_random();
        test_reset_mid_served();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for one core of the 5-stage MIPS pipeline.
- Generates write-enable and flush for the four stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Combines icache/dcache hits, load-use hazards, branch/jump redirects and halt into one coherent stall/flush decision.
- Remembers a dcache access already served while the pipe is frozen, so the access is never re-issued and its load data is not lost.

Parameters:
- WORD_W, 32, datapath word width
- REG_W, 5, register-index width

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- ihit  in  1  icache hit for current fetch
- dhit  in  1  dcache hit for current EX/MEM access
- dmemload  in  WORD_W  dcache read data
- exmem_dREN  in  1  EX/MEM stage requests load
- exmem_dWEN  in  1  EX/MEM stage requests store
- exmem_redirect  in  1  taken branch/jump resolved in EX/MEM
- idex_MemtoReg  in  1  ID/EX instruction is a load
- idex_wsel  in  REG_W  ID/EX destination register
- ifid_rs  in  REG_W  IF/ID source register rs
- ifid_rt  in  REG_W  IF/ID source register rt
- memwb_halt  in  1  halt has reached MEM/WB
- pc_wen  out  1  PC update enable
- ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  stage latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble into stage latch
- dREN_out, dWEN_out  out  1 each  masked dcache request
- dmemload_out  out  WORD_W  load data to EX/MEM→MEM/WB path
- halt  out  1  sticky core halted

Behaviour:
- Registered state: `st` ∈ {RUN, SERVED, HALTED}, plus `hold_data[WORD_W]`.
- Derived signals:
  - `mem_req = exmem_dREN | exmem_dWEN`
  - `dstall = mem_req & ~dhit & (st != SERVED)`
  - `lu = idex_MemtoReg & (idex_wsel != 0) & (idex_wsel == ifid_rs | idex_wsel == ifid_rt)`
  - `adv = ihit & ~dstall & (st != HALTED)`
- Outputs:
  - `memwb_wen = exmem_wen = adv`
  - `idex_wen = adv`
  - `ifid_wen = pc_wen = adv & ~lu`
  - `idex_flush = adv & (lu | exmem_redirect)`
  - `ifid_flush = exmem_flush = adv & exmem_redirect`
  - Redirect beats load-use: both fire → PC takes redirect, `pc_wen = adv`.
- Dcache request masking:
  - `dREN_out = exmem_dREN & (st == RUN)`
  - `dWEN_out = exmem_dWEN & (st == RUN)`
  - `dmemload_out = (st == SERVED) ? hold_data : dmemload`
- Transitions, evaluated on clk rising edge:
  - RUN → SERVED: `mem_req & dhit & ~adv` (icache still missing). Capture `hold_data <= dmemload`.
  - SERVED → RUN: `adv`.
  - any → HALTED: `memwb_halt & memwb_wen`. This has top priority.
  - HALTED is absorbing until reset.
- In HALTED: all wen, flush, pc_wen, dREN_out and dWEN_out are 0; `halt = 1`.
- Reset (nRst low, asynchronous): `st = RUN`, `hold_data = 0`, `halt = 0`. While nRst is low, all wen, flush and d*_out outputs are forced 0.
- Latency:
  - Decisions are combinational, same cycle.
  - SERVED and HALTED take effect the cycle after the triggering edge.
- Boundary cases:
  - `dhit` and `ihit` both high in RUN → advance; stay in RUN.
  - Redirect while frozen → no flush until `adv`.
  - `idex_wsel == 0` is never a hazard.
  - Halt coincident with redirect → HALTED wins; flush is irrelevant.
  - Reset asserted mid-SERVED → `hold_data` is discarded.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds outputs `stall_cnt[32]` and `flush_cnt[32]`:
  - `stall_cnt` increments on every non-HALTED cycle with `~adv`.
  - `flush_cnt` increments on each cycle where `ifid_flush | idex_flush`.
  - Both counters wrap modulo 2^32, reset to 0, and freeze in HALTED.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add `pctrl_state_t` enum (RUN/SERVED/HALTED) to `cpu_types_pkg`; reuse `word_t` and `regbits_t`.
- One sub-module, `hazard_detect`: purely combinational `lu` computation, reusable by the second core's forwarding work.

Test Plan:
- Load-use: `idex_MemtoReg=1`, `idex_wsel=5`, `ifid_rs=5`, `ihit=1` → `pc_wen=0`, `ifid_wen=0`, `idex_flush=1`, `exmem_wen=1` for exactly one cycle.
- `idex_wsel=0`, `ifid_rt=0`, load → no stall.
- Dcache miss: `exmem_dREN=1`, `dhit=0` for 3 cycles → all wen 0 for those cycles. Then `dhit=1` → advance; `dREN_out` stays 1 throughout.
- Served-while-imiss: `dREN=1`, `dhit=1`, `dmemload=0xDEADBEEF`, `ihit=0` → next cycle `st=SERVED`, `dREN_out=0`, `dmemload_out=0xDEADBEEF` while `dmemload` changes. `ihit=1` → advance, return to RUN.
- Redirect: `exmem_redirect=1` with `ihit=1` → `ifid_flush=idex_flush=exmem_flush=1` one cycle. The same stimulus with `ihit=0` → no flush until `ihit` rises.
- Halt: `memwb_halt=1`, `adv=1` → next cycle `halt=1` and all enables 0 regardless of inputs. Pulse nRst low → `halt=0`, `st=RUN`. With PIPE_PERF_CNT_EN defined, `stall_cnt` matches the stall cycles of the preceding scenarios.
